// File: rtl/objects_layer_compositor_if.sv
// Per-pixel drawing bus between the object layers/VGA sync and the layer compositor.
// Signals keep the names of the existing drawing interface.
interface objects_layer_compositor_if #(
    parameter int unsigned NUM_LAYERS = 4
);
    logic                             startOfFrame;
    logic [NUM_LAYERS-1:0]            drawingRequests;
    logic [NUM_LAYERS-1:0][7:0]       layersRGB;
    logic [7:0]                       backGroundRGB;
    logic [7:0]                       RGBOut;
    logic [NUM_LAYERS-2:0]            collisionFlags;
    logic                             collisionPulse;

    modport master (
        output startOfFrame, drawingRequests, layersRGB, backGroundRGB,
        input  RGBOut, collisionFlags, collisionPulse
    );

    modport slave (
        input  startOfFrame, drawingRequests, layersRGB, backGroundRGB,
        output RGBOut, collisionFlags, collisionPulse
    );
endinterface

// File: rtl/objects_layer_compositor.sv
// Priority mux of NUM_LAYERS object layers over a background into one registered pixel.
// Define COLLISION_DETECT_EN to build the per-frame layer-0 overlap detector.
module objects_layer_compositor #(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter logic [7:0]  TRANSPARENT = 8'hFF
) (
    input logic                      clk,
    input logic                      resetN,
    objects_layer_compositor_if.slave bus
);

    logic [7:0] rgb_d, rgb_q;
    logic       found;

    // Lowest-index requesting layer wins; a transparent winner shows the background.
    always_comb begin
        rgb_d = bus.backGroundRGB;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && bus.drawingRequests[i]) begin
                found = 1'b1;
                rgb_d = bus.layersRGB[i];
            end
        end
        if (found && (rgb_d == TRANSPARENT)) begin
            rgb_d = bus.backGroundRGB;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q <= 8'h00;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.RGBOut = rgb_q;

`ifdef COLLISION_DETECT_EN
    typedef enum logic {StWaitSof, StAccum} state_e;

    state_e                state_d, state_q;
    logic [NUM_LAYERS-2:0] hit;
    logic [NUM_LAYERS-2:0] hit_acc_d, hit_acc_q;
    logic [NUM_LAYERS-2:0] flags_d, flags_q;
    logic                  pulse_d, pulse_q;

    assign hit = {(NUM_LAYERS-1){bus.drawingRequests[0]}} & bus.drawingRequests[NUM_LAYERS-1:1];

    // The SOF cycle itself is counted in the frame it opens.
    always_comb begin
        state_d   = state_q;
        hit_acc_d = hit_acc_q;
        flags_d   = flags_q;
        pulse_d   = 1'b0;
        case (state_q)
            StWaitSof: begin
                hit_acc_d = '0;
                if (bus.startOfFrame) begin
                    state_d   = StAccum;
                    hit_acc_d = hit;
                end
            end
            StAccum: begin
                if (bus.startOfFrame) begin
                    flags_d   = hit_acc_q;
                    pulse_d   = |hit_acc_q;
                    hit_acc_d = hit;
                end else begin
                    hit_acc_d = hit_acc_q | hit;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= StWaitSof;
            hit_acc_q <= '0;
            flags_q   <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_acc_q <= hit_acc_d;
            flags_q   <= flags_d;
            pulse_q   <= pulse_d;
        end
    end

    assign bus.collisionFlags = flags_q;
    assign bus.collisionPulse = pulse_q;
`else
    logic unused_sof;

    assign unused_sof         = bus.startOfFrame;
    assign bus.collisionFlags = '0;
    assign bus.collisionPulse = 1'b0;
`endif

endmodule

// File: tb/tb_objects_layer_compositor.sv
// Directed plus randomized bench for objects_layer_compositor against a frame-level model.
// Collision expectations follow COLLISION_DETECT_EN, matching the build of the design.
module tb_objects_layer_compositor;

    localparam int unsigned NL = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    objects_layer_compositor_if #(.NUM_LAYERS(NL)) bus ();

    objects_layer_compositor #(
        .NUM_LAYERS (NL),
        .TRANSPARENT(8'hFF)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] exp_rgb;
    logic [2:0] exp_flags;
    logic       exp_pulse;
    bit         in_frame;
    bit         seen [1:3];

    function automatic logic [7:0] pick(input logic [3:0] req, input logic [3:0][7:0] rgb,
                                        input logic [7:0] bg);
        for (int i = 0; i < 4; i++) begin
            if (req[i]) return (rgb[i] == 8'hFF) ? bg : rgb[i];
        end
        return bg;
    endfunction

    task automatic model_reset();
        exp_rgb   = 8'h00;
        exp_flags = 3'b000;
        exp_pulse = 1'b0;
        in_frame  = 0;
        for (int i = 1; i <= 3; i++) seen[i] = 0;
    endtask

    task automatic model_clock(input logic sof, input logic [3:0] req,
                               input logic [3:0][7:0] rgb, input logic [7:0] bg);
        exp_rgb = pick(req, rgb, bg);
`ifdef COLLISION_DETECT_EN
        exp_pulse = 1'b0;
        if (sof) begin
            if (in_frame) begin
                for (int i = 1; i <= 3; i++) exp_flags[i-1] = seen[i];
                exp_pulse = seen[1] | seen[2] | seen[3];
            end
            in_frame = 1;
            for (int i = 1; i <= 3; i++) seen[i] = req[0] && req[i];
        end else if (in_frame) begin
            for (int i = 1; i <= 3; i++) seen[i] = seen[i] || (req[0] && req[i]);
        end
`else
        exp_flags = 3'b000;
        exp_pulse = 1'b0;
`endif
    endtask

    task automatic check_all(input string tag);
        compared++;
        assert (bus.RGBOut === exp_rgb) else begin
            mismatched++;
            $error("FAIL %s rgb observed=%h expected=%h", tag, bus.RGBOut, exp_rgb);
        end
        compared++;
        assert (bus.collisionFlags === exp_flags) else begin
            mismatched++;
            $error("FAIL %s flags observed=%b expected=%b", tag, bus.collisionFlags, exp_flags);
        end
        compared++;
        assert (bus.collisionPulse === exp_pulse) else begin
            mismatched++;
            $error("FAIL %s pulse observed=%b expected=%b", tag, bus.collisionPulse, exp_pulse);
        end
    endtask

    task automatic cycle(input string tag, input logic sof, input logic [3:0] req,
                         input logic [3:0][7:0] rgb, input logic [7:0] bg);
        @(negedge clk);
        bus.startOfFrame    = sof;
        bus.drawingRequests = req;
        bus.layersRGB       = rgb;
        bus.backGroundRGB   = bg;
        model_clock(sof, req, rgb, bg);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset lands between clock edges; outputs must clear before any edge arrives.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        #2;
        resetN = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    logic [3:0][7:0] rgbv;
    logic [3:0][7:0] zrgb;

    initial begin
        zrgb                = '0;
        bus.startOfFrame    = 1'b0;
        bus.drawingRequests = '0;
        bus.layersRGB       = '0;
        bus.backGroundRGB   = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        resetN = 1'b1;

        // Priority: layer 1 beats layer 2
        rgbv = {8'h00, 8'hE0, 8'h1C, 8'h00};
        cycle("prio", 1'b0, 4'b0110, rgbv, 8'h25);
        compared++;
        assert (bus.RGBOut === 8'h1C) else begin
            mismatched++;
            $error("FAIL prio_const observed=%h expected=%h", bus.RGBOut, 8'h1C);
        end

        // Background and transparency
        cycle("bg", 1'b0, 4'b0000, rgbv, 8'h25);
        compared++;
        assert (bus.RGBOut === 8'h25) else begin
            mismatched++;
            $error("FAIL bg_const observed=%h expected=%h", bus.RGBOut, 8'h25);
        end
        rgbv = {8'h11, 8'h22, 8'h33, 8'hFF};
        cycle("transp", 1'b0, 4'b0001, rgbv, 8'h25);
        compared++;
        assert (bus.RGBOut === 8'h25) else begin
            mismatched++;
            $error("FAIL transp_const observed=%h expected=%h", bus.RGBOut, 8'h25);
        end

        // Partial first frame after reset must not report
        mid_reset("rst_a");
        rgbv = {8'h44, 8'h55, 8'h66, 8'h77};
        for (int i = 0; i < 10; i++) cycle("partial", 1'b0, 4'b0011, rgbv, 8'h01);
        cycle("partial_sof", 1'b1, 4'b0000, rgbv, 8'h01);
        cycle("partial_after", 1'b0, 4'b0000, rgbv, 8'h01);

        // Collision latch on layer 2
        cycle("col_sof1", 1'b1, 4'b0000, rgbv, 8'h02);
        cycle("col_hit", 1'b0, 4'b0101, rgbv, 8'h02);
        cycle("col_sof2", 1'b1, 4'b0000, rgbv, 8'h02);
`ifdef COLLISION_DETECT_EN
        compared++;
        assert (bus.collisionFlags === 3'b010 && bus.collisionPulse === 1'b1) else begin
            mismatched++;
            $error("FAIL col_const observed=%b/%b expected=010/1",
                   bus.collisionFlags, bus.collisionPulse);
        end
`endif
        cycle("col_after", 1'b0, 4'b0000, rgbv, 8'h02);
        cycle("col_b2b", 1'b1, 4'b0000, rgbv, 8'h02);
        cycle("col_b2b2", 1'b1, 4'b1001, rgbv, 8'h02);
        cycle("col_b2b3", 1'b1, 4'b0000, rgbv, 8'h02);

        // Reset mid-frame with a pending hit on layer 3
        cycle("mid_sof", 1'b1, 4'b0000, rgbv, 8'h03);
        cycle("mid_hit", 1'b0, 4'b1001, rgbv, 8'h03);
        mid_reset("rst_b");
        cycle("mid_sof_a", 1'b1, 4'b0000, rgbv, 8'h03);
        for (int i = 0; i < 5; i++) cycle("mid_clean", 1'b0, 4'b0010, rgbv, 8'h03);
        cycle("mid_sof_b", 1'b1, 4'b0000, rgbv, 8'h03);
        cycle("mid_end", 1'b0, 4'b0000, rgbv, 8'h03);

        // Randomized traffic with occasional SOF and transparent pixels
        for (int n = 0; n < 3000; n++) begin
            logic       sof;
            logic [3:0] req;
            logic [7:0] bg;
            for (int k = 0; k < 4; k++) begin
                rgbv[k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            end
            req = 4'($urandom);
            if ($urandom_range(0, 3) != 0) req[0] = 1'b0;
            sof = ($urandom_range(0, 29) == 0);
            bg  = 8'($urandom);
            cycle("rand", sof, req, rgbv, bg);
            if (n == 1500) mid_reset("rst_rand");
        end

        cycle("final", 1'b0, 4'b0000, zrgb, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
